game_countdown_timer: RTL and testbench
=======================================

// Module: game_countdown_timer
// PURPOSE
//  Parametrised game timer: counts whole seconds up or down between 0 and START_SEC,
//  pulses/holds done at the terminal value, and drives a multiplexed N_DIGITS 7-seg display.
//  Sits between the game FSM (start/en/cw) and the board display pins.
//  Replaces the fixed 10-second, single-mode timer with a start/pause FSM,
//  multi-digit BCD time and programmable rates.
// PARAMETERS
//  TICK_DIV      100_000_000  clk cycles per 1-second tick (>=2)
//  START_SEC     10           count limit in seconds; must fit in N_DIGITS decimal digits
//  N_DIGITS      4            displayed BCD digits / anode lines (1..8)
//  REFRESH_BITS  18           scan counter width; digit changes every 2^(REFRESH_BITS-$clog2(N_DIGITS)) cycles
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            1-cycle pulse: (re)load and run
//  en         in   1            1 = run, 0 = pause (prescaler frozen)
//  cw         in   1            count direction latched at start: 1 = up 0->START_SEC, 0 = down START_SEC->0
//  sseg       out  7            active-low segments {g,f,e,d,c,b,a} of the scanned digit
//  an         out  N_DIGITS     active-low one-hot anode select
//  done       out  1            high while in DONE
//  time_sseg  out  7*N_DIGITS   all digit patterns, digit 0 (units) in [6:0]
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, scan=0, dir=down, BCD=START_SEC; done=0,
//   time_sseg shows START_SEC, an=~1 (digit 0 active), sseg=digit-0 pattern.
//  FSM IDLE/RUN/PAUSE/DONE; start has priority over every other input.
//   any state + start: load BCD (0 if cw else START_SEC), latch dir=cw, prescaler=0 -> RUN.
//   RUN + !en -> PAUSE (no tick this cycle); PAUSE + en -> RUN, prescaler resumes where held.
//   RUN: prescaler increments; at TICK_DIV-1 wraps to 0 and emits tick.
//   tick: BCD +1 (up) or -1 (down), per-digit carry/borrow 9<->0 across all digits.
//   After tick, if BCD == terminal (START_SEC up, 0 down) -> DONE same edge; done high next cycle.
//   DONE: BCD frozen, done held high until start or rst; en/cw ignored.
//   IDLE: BCD frozen, en/cw ignored.
//  Tick latency: first tick exactly TICK_DIV cycles after the start cycle with en held high;
//   done rises TICK_DIV*START_SEC+1 cycles after start.
//  START_SEC=0: start -> RUN, first tick -> DONE, BCD stays 0 (no wrap below 0 / past limit).
//  Display: scan counter free-runs (also in IDLE/PAUSE/DONE); sel = top $clog2(N_DIGITS) bits,
//   values >= N_DIGITS map to digit 0. an[sel]=0, others 1; sseg = time_sseg[7*sel +: 7].
//   Leading zeros shown. Encoding 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; other code = 0111111 (dash).
//  All outputs registered; sseg/an change on the same edge as sel.
// STRUCTURE
//  Package game_timer_pkg: state_t enum {IDLE,RUN,PAUSE,DONE}; SSEG_LUT[10] constant;
//   function bcd_to_sseg(logic [3:0]) -> logic [6:0].
//  Sub-module sseg_scan #(N_DIGITS,REFRESH_BITS): scan counter, digit select, anode decode,
//   segment mux; takes time_sseg, outputs sseg/an. FSM, prescaler and BCD counter stay in top.
// TESTING (TICK_DIV=4, START_SEC=10, N_DIGITS=4, REFRESH_BITS=4)
//  1 rst 2 cycles -> done=0, time_sseg = {0,0,1,0} patterns, an=4'b1110.
//  2 start, cw=0, en=1 -> BCD 0009 at cycle 4, 0000 at cycle 40, done=1 at cycle 41 and held.
//  3 start, cw=1, en=1 -> 0001..0009, 0010 at cycle 40 with 9->10 carry, done=1 next cycle.
//  4 run down, drop en for 7 cycles mid-second -> BCD frozen, tick delayed exactly 7 cycles.
//  5 start pulse in DONE and mid-RUN -> reload to 0010 (down), done=0 next cycle; rst mid-RUN -> reset values.
//  6 free scan -> an cycles 1110,1101,1011,0111 every 4 clk; sseg matches selected digit.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and 7-segment helpers for the game countdown timer.
package game_timer_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_t;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SsegLut [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SsegDash = 7'b0111111;

  function automatic logic [6:0] bcd_to_sseg(logic [3:0] d);
    return (d < 4'd10) ? SsegLut[d] : SsegDash;
  endfunction

  // Up to 8 BCD digits, units in [3:0].
  function automatic logic [31:0] int_to_bcd(int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_scan.sv
// Free-running digit scanner: picks one digit pattern per refresh slot and drives its anode.
module sseg_scan #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7*N_DIGITS-1:0] time_sseg_i,
  output logic [6:0]            sseg_o,
  output logic [N_DIGITS-1:0]   an_o
);

  localparam int unsigned SelW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [SelW-1:0]         sel;
  logic [6:0]              sseg_q, sseg_d;
  logic [N_DIGITS-1:0]     an_q, an_d;

  // Select derives from the next scan value so sseg/an update on the edge sel changes.
  always_comb begin
    scan_d = scan_q + REFRESH_BITS'(1);
    sel    = scan_d[REFRESH_BITS-1 -: SelW];
    if (32'(sel) >= N_DIGITS) sel = '0;
    an_d   = ~(N_DIGITS'(1) << sel);
    sseg_d = time_sseg_i[7*sel +: 7];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_q <= '0;
      an_q   <= ~N_DIGITS'(1);
      sseg_q <= time_sseg_i[6:0];
    end else begin
      scan_q <= scan_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign sseg_o = sseg_q;
  assign an_o   = an_q;

endmodule

// File: rtl/game_countdown_timer.sv
// Game timer: start/pause FSM, 1-second prescaler, BCD up/down counter and scanned 7-seg output.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned START_SEC    = 10,
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  input  logic                  cw,
  output logic [6:0]            sseg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  done,
  output logic [7*N_DIGITS-1:0] time_sseg
);

  localparam int unsigned BcdW   = 4 * N_DIGITS;
  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [31:0] StartBcd32 = int_to_bcd(START_SEC);
  localparam logic [BcdW-1:0] StartBcd = StartBcd32[BcdW-1:0];

  function automatic logic [7*N_DIGITS-1:0] encode(logic [BcdW-1:0] b);
    logic [7*N_DIGITS-1:0] r;
    for (int i = 0; i < N_DIGITS; i++) r[7*i +: 7] = bcd_to_sseg(b[4*i +: 4]);
    return r;
  endfunction

  localparam logic [7*N_DIGITS-1:0] StartSseg = encode(StartBcd);

  state_t                state_q, state_d;
  logic [PrescW-1:0]     presc_q, presc_d;
  logic [BcdW-1:0]       bcd_q, bcd_d, bcd_inc, bcd_dec, term;
  logic                  dir_up_q, dir_up_d;
  logic                  done_q;
  logic [7*N_DIGITS-1:0] time_sseg_q, time_sseg_nxt;
  logic                  inc_c, dec_b;

  // Decimal increment/decrement with per-digit carry/borrow.
  always_comb begin
    bcd_inc = bcd_q;
    bcd_dec = bcd_q;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (inc_c) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  assign term = dir_up_q ? StartBcd : '0;

  // PAUSE with en counts like RUN so a pause delays the tick by exactly its length.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    bcd_d    = bcd_q;
    dir_up_d = dir_up_q;
    if (start) begin
      bcd_d    = cw ? '0 : StartBcd;
      dir_up_d = cw;
      presc_d  = '0;
      state_d  = StRun;
    end else if ((state_q == StRun || state_q == StPause) && en) begin
      state_d = StRun;
      if (presc_q == PrescW'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (bcd_q != term) bcd_d = dir_up_q ? bcd_inc : bcd_dec;
        if (bcd_q == term || bcd_d == term) state_d = StDone;
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end else if (state_q == StRun) begin
      state_d = StPause;
    end
  end

  assign time_sseg_nxt = rst ? StartSseg : encode(bcd_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      bcd_q       <= StartBcd;
      dir_up_q    <= 1'b0;
      done_q      <= 1'b0;
      time_sseg_q <= StartSseg;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      bcd_q       <= bcd_d;
      dir_up_q    <= dir_up_d;
      done_q      <= (state_q == StDone);
      time_sseg_q <= time_sseg_nxt;
    end
  end

  sseg_scan #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_BITS(REFRESH_BITS)
  ) u_scan (
    .clk_i      (clk),
    .rst_i      (rst),
    .time_sseg_i(time_sseg_nxt),
    .sseg_o     (sseg),
    .an_o       (an)
  );

  assign done      = done_q;
  assign time_sseg = time_sseg_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench: stimulus schedules expected outputs per cycle, a negedge monitor checks them.
module tb_game_countdown_timer;

  localparam int unsigned TickDiv     = 4;
  localparam int unsigned StartSec    = 10;
  localparam int unsigned NDigits     = 4;
  localparam int unsigned RefreshBits = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        en = 1'b1;
  logic        cw = 1'b0;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        done;
  logic [27:0] time_sseg;

  game_countdown_timer #(
    .TICK_DIV    (TickDiv),
    .START_SEC   (StartSec),
    .N_DIGITS    (NDigits),
    .REFRESH_BITS(RefreshBits)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .cw       (cw),
    .sseg     (sseg),
    .an       (an),
    .done     (done),
    .time_sseg(time_sseg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {KTime, KDone, KAn, KSseg} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [27:0] val;
  } chk_t;

  chk_t sb[$];
  chk_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [27:0] pat(int d3, int d2, int d1, int d0);
    return {seg_tbl[d3], seg_tbl[d2], seg_tbl[d1], seg_tbl[d0]};
  endfunction

  task automatic expect_at(input int c, input kind_e k, input logic [27:0] v);
    chk_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Leaves the caller #1 after posedge e-1, so inputs set next are sampled at edge e.
  task automatic goto(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic dir, output int s);
    s     = cyc + 1;
    start = 1'b1;
    cw    = dir;
    @(posedge clk);
    #1;
    start = 1'b0;
    cw    = ~dir;
  endtask

  always @(negedge clk) begin
    logic [27:0] act;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      case (mon_e.kind)
        KTime:   act = time_sseg;
        KDone:   act = 28'(done);
        KAn:     act = 28'(an);
        default: act = 28'(sseg);
      endcase
      if (mon_e.cyc != cyc || act != mon_e.val) begin
        miscompares++;
        $display("FAIL %s at cycle %0d (due %0d): got %h, want %h",
                 mon_e.kind.name(), cyc, mon_e.cyc, act, mon_e.val);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, s2, r;

    // Reset state and free-running scan while idle.
    expect_at(2, KDone, 28'd0);
    expect_at(2, KTime, pat(0, 0, 1, 0));
    expect_at(2, KAn, 28'hE);
    expect_at(2, KSseg, 28'(seg_tbl[0]));
    expect_at(6, KAn, 28'hD);
    expect_at(6, KSseg, 28'(seg_tbl[1]));
    expect_at(10, KAn, 28'hB);
    expect_at(10, KSseg, 28'(seg_tbl[0]));
    expect_at(14, KAn, 28'h7);
    expect_at(14, KSseg, 28'(seg_tbl[0]));
    expect_at(15, KTime, pat(0, 0, 1, 0));
    expect_at(18, KAn, 28'hE);
    goto(3);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL direct reset done: got %b", done);
    end
    vectors++;
    if (an !== 4'hE) begin
      miscompares++;
      $display("FAIL direct reset an: got %h", an);
    end
    vectors++;
    if (time_sseg !== pat(0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL direct reset time_sseg: got %h", time_sseg);
    end
    vectors++;
    if (sseg !== seg_tbl[0]) begin
      miscompares++;
      $display("FAIL direct reset sseg: got %b", sseg);
    end
    rst = 1'b0;

    // Count down 10 -> 0.
    goto(20);
    pulse_start(1'b0, s);
    expect_at(s, KTime, pat(0, 0, 1, 0));
    expect_at(s + 3, KTime, pat(0, 0, 1, 0));
    expect_at(s + 4, KTime, pat(0, 0, 0, 9));
    expect_at(s + 8, KTime, pat(0, 0, 0, 8));
    expect_at(s + 40, KTime, pat(0, 0, 0, 0));
    expect_at(s + 40, KDone, 28'd0);
    expect_at(s + 41, KDone, 28'd1);
    expect_at(s + 50, KDone, 28'd1);
    expect_at(s + 50, KTime, pat(0, 0, 0, 0));

    // Count up 0 -> 10 with the 9 -> 10 carry.
    goto(s + 55);
    pulse_start(1'b1, s);
    expect_at(s, KTime, pat(0, 0, 0, 0));
    expect_at(s + 1, KDone, 28'd0);
    expect_at(s + 4, KTime, pat(0, 0, 0, 1));
    expect_at(s + 36, KTime, pat(0, 0, 0, 9));
    expect_at(s + 40, KTime, pat(0, 0, 1, 0));
    expect_at(s + 40, KDone, 28'd0);
    expect_at(s + 41, KDone, 28'd1);
    expect_at(s + 45, KTime, pat(0, 0, 1, 0));

    // Restart from DONE, then a 7-cycle pause mid-second.
    goto(s + 50);
    pulse_start(1'b0, s);
    expect_at(s, KTime, pat(0, 0, 1, 0));
    expect_at(s + 1, KDone, 28'd0);
    expect_at(s + 5, KTime, pat(0, 0, 1, 0));
    expect_at(s + 10, KTime, pat(0, 0, 1, 0));
    expect_at(s + 11, KTime, pat(0, 0, 0, 9));
    expect_at(s + 15, KTime, pat(0, 0, 0, 8));
    goto(s + 2);
    en = 1'b0;
    goto(s + 9);
    en = 1'b1;

    // Restart mid-RUN, then reset mid-RUN.
    goto(s + 17);
    pulse_start(1'b0, s2);
    expect_at(s2, KTime, pat(0, 0, 1, 0));
    expect_at(s2 + 4, KTime, pat(0, 0, 0, 9));
    goto(s2 + 6);
    r = cyc + 1;
    expect_at(r, KTime, pat(0, 0, 1, 0));
    expect_at(r, KDone, 28'd0);
    expect_at(r, KAn, 28'hE);
    expect_at(r, KSseg, 28'(seg_tbl[0]));
    expect_at(r + 4, KAn, 28'hD);
    expect_at(r + 4, KSseg, 28'(seg_tbl[1]));
    expect_at(r + 8, KTime, pat(0, 0, 1, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    goto(r + 12);
    @(negedge clk);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s due cycle %0d never checked", mon_e.kind.name(), mon_e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
